// File: rtl/mbist_march_ctrl.sv
`timescale 1ns/1ps
// March C- BIST controller for a 2^ADDR_W x DATA_W single-port SRAM, with an on-chip comparator and fail capture.
// Optional MBIST_FAIL_STOP_EN: the first miscompare ends the test.
module mbist_march_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [CNT_W-1:0]  fail_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
  } state_t;

  localparam logic [ADDR_W:0]  CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  CNT_TOP  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [CNT_W-1:0] FAIL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W:0]   cnt;
  logic              phase;      // 0: read slot of a pair, 1: write slot
  logic              cmp_vld;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;
  logic [2:0]        cmp_elem;

  logic              up;
  logic [ADDR_W:0]   step;
  logic              last;
  logic              miscmp;
  logic [2:0]        elem;
  logic [DATA_W-1:0] wr_bg;
  logic [DATA_W-1:0] rd_bg;
  state_t            next_elem;
  logic [ADDR_W:0]   next_start;

  // The extra counter bit flags the step past either end of the array.
  always_comb begin
    up         = (state == S_M0) || (state == S_M1) || (state == S_M2);
    step       = up ? (cnt + CNT_ONE) : (cnt - CNT_ONE);
    last       = step[ADDR_W];
    miscmp     = busy && cmp_vld && (mem_rdata != cmp_exp);
    wr_bg      = ((state == S_M1) || (state == S_M3)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    rd_bg      = ((state == S_M2) || (state == S_M4)) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    next_start = (state == S_M1) ? {(ADDR_W+1){1'b0}} : CNT_TOP;
    elem       = 3'd0;
    next_elem  = S_IDLE;
    case (state)
      S_M1: begin elem = 3'd1; next_elem = S_M2; end
      S_M2: begin elem = 3'd2; next_elem = S_M3; end
      S_M3: begin elem = 3'd3; next_elem = S_M4; end
      S_M4: begin elem = 3'd4; next_elem = S_M5; end
      S_M5: begin elem = 3'd5; next_elem = S_FLUSH; end
      default: begin elem = 3'd0; next_elem = S_IDLE; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      phase      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_elem  <= '0;
      fail_count <= '0;
      cmp_vld    <= 1'b0;
      cmp_exp    <= '0;
      cmp_addr   <= '0;
      cmp_elem   <= '0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= '0;
      cmp_vld   <= mem_re;
      cmp_exp   <= rd_bg;
      cmp_addr  <= mem_addr;
      cmp_elem  <= elem;

      if (miscmp) begin
        fail <= 1'b1;
        if (fail_count != {CNT_W{1'b1}}) fail_count <= fail_count + FAIL_ONE;
        if (!fail) begin
          fail_addr <= cmp_addr;
          fail_elem <= cmp_elem;
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= '0;
            fail_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b1;
            state      <= S_M0;
            cnt        <= '0;
            phase      <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b1;
          end
        end
        S_M0: begin
          if (last) begin
            state    <= S_M1;
            cnt      <= '0;
            phase    <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= '0;
          end else begin
            cnt      <= step;
            mem_we   <= 1'b1;
            mem_addr <= step[ADDR_W-1:0];
          end
        end
        S_M1, S_M2, S_M3, S_M4: begin
          if (!phase) begin
            phase     <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= wr_bg;
          end else if (last) begin
            state    <= next_elem;
            cnt      <= next_start;
            phase    <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= next_start[ADDR_W-1:0];
          end else begin
            cnt      <= step;
            phase    <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= step[ADDR_W-1:0];
          end
        end
        S_M5: begin
          if (last) begin
            state <= S_FLUSH;
          end else begin
            cnt      <= step;
            mem_re   <= 1'b1;
            mem_addr <= step[ADDR_W-1:0];
          end
        end
        S_FLUSH: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

`ifdef MBIST_FAIL_STOP_EN
      if (miscmp) begin
        state     <= S_DONE;
        busy      <= 1'b0;
        done      <= 1'b1;
        mem_we    <= 1'b0;
        mem_re    <= 1'b0;
        mem_wdata <= '0;
        cmp_vld   <= 1'b0;
      end
`else
`endif
    end
  end

endmodule
